// File: rtl/twiddle_stage_ctrl_pkg.sv
// Shared constants and types for the twiddle stage controller.
// Holds the default FFT geometry, twiddle-class encodings, FSM state type
// and the sideband beat struct carried alongside the multiplier pipeline.
package twiddle_stage_ctrl_pkg;

   // Address width of a beat index; a one-beat frame still needs a 1-bit bus.
   function automatic int addr_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

   localparam int FFT_N = 128;
   localparam int FFT_P = 4;
   localparam int FFT_B = FFT_N / FFT_P;
   localparam int TW_AW = addr_w(FFT_B);

   // num_ciclo encodings seen by the multipliers (2'b10 also means x1).
   localparam logic [1:0] TW_ONE  = 2'b00;
   localparam logic [1:0] TW_NEGJ = 2'b01;
   localparam logic [1:0] TW_CSD  = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic vld;
      logic sof;
      logic eof;
   } sb_t;

endpackage

// File: rtl/twiddle_stage_ctrl_if.sv
// Handshake and control bundle between upstream, controller and multipliers.
// slave: controller side (takes in_valid/in_sof/out_ready, drives the rest).
// master: environment side (drives in_valid/in_sof/out_ready).
interface twiddle_stage_ctrl_if
   import twiddle_stage_ctrl_pkg::*;
#(
   parameter int AW = TW_AW
) ();

   logic          in_valid;
   logic          in_sof;
   logic          in_ready;
   logic          out_ready;
   logic [1:0]    num_ciclo;
   logic [AW-1:0] tw_addr;
   logic          pipe_en;
   logic          out_valid;
   logic          out_sof;
   logic          out_eof;
   logic          err_sof;
   logic [15:0]   frame_cnt;

   modport slave (
      input  in_valid, in_sof, out_ready,
      output in_ready, num_ciclo, tw_addr, pipe_en,
             out_valid, out_sof, out_eof, err_sof, frame_cnt
   );

   modport master (
      output in_valid, in_sof, out_ready,
      input  in_ready, num_ciclo, tw_addr, pipe_en,
             out_valid, out_sof, out_eof, err_sof, frame_cnt
   );

endinterface

// File: rtl/twiddle_stage_ctrl_sideband_pipe.sv
// sideband_pipe: LAT-deep shift register of {vld,sof,eof} matching the multiplier depth.
// Latency: LAT enabled cycles from sb_in to sb_out.
// Backpressure: every stage holds while en is low; reset clears all stages.
module sideband_pipe
   import twiddle_stage_ctrl_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  sb_t  sb_in,
   output sb_t  sb_out
);

   sb_t stg_q [LAT];
   sb_t stg_d [LAT];

   always_comb begin
      for (int i = 0; i < LAT; i++) begin
         stg_d[i] = stg_q[i];
      end
      if (en) begin
         stg_d[0] = sb_in;
         for (int i = 1; i < LAT; i++) begin
            stg_d[i] = stg_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LAT; i++) begin
            stg_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < LAT; i++) begin
            stg_q[i] <= stg_d[i];
         end
      end
   end

   assign sb_out = stg_q[LAT-1];

endmodule

// File: rtl/twiddle_stage_ctrl.sv
// Twiddle stage controller: frames beats, drives twiddle address/class and sideband.
// Latency: tw_addr/num_ciclo combinational in accept cycle; out_* LAT enabled cycles later.
// Backpressure: pipe_en = !out_valid || out_ready; in_ready = pipe_en, all state holds when low.
// Ports: clk, rst (async active-low), bus (slave modport of twiddle_stage_ctrl_if).
module twiddle_stage_ctrl
   import twiddle_stage_ctrl_pkg::*;
#(
   parameter int N   = FFT_N,
   parameter int P   = FFT_P,
   parameter int LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   twiddle_stage_ctrl_if.slave bus
);

   localparam int B  = N / P;
   localparam int AW = addr_w(B);
   localparam logic [AW-1:0] LAST_K = AW'(B - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] bcnt_q, bcnt_d;
   logic          err_q, err_d;
   logic [15:0]   fc_q, fc_d;

   logic          pipe_en;
   logic          accept;
   logic [AW-1:0] k;
   logic          last;
   sb_t           sb_in;
   sb_t           sb_out;

   always_comb begin
      pipe_en = !sb_out.vld || bus.out_ready;
      accept  = bus.in_valid && pipe_en;

      // Beat index: any sof beat and any IDLE beat map to index 0.
      k = '0;
      if (state_q == ST_RUN && !bus.in_sof) begin
         k = bcnt_q;
      end
      last = (k == LAST_K);

      state_d = state_q;
      bcnt_d  = bcnt_q;
      err_d   = 1'b0;
      sb_in   = '0;

      if (accept) begin
         if (state_q == ST_IDLE && !bus.in_sof) begin
            // Orphan beat outside a frame: swallow it and flag.
            err_d = 1'b1;
         end else begin
            // A sof while RUN abandons the open frame without eof.
            err_d     = (state_q == ST_RUN) && bus.in_sof;
            sb_in.vld = 1'b1;
            sb_in.sof = bus.in_sof;
            sb_in.eof = last;
            if (last) begin
               state_d = ST_IDLE;
               bcnt_d  = '0;
            end else begin
               state_d = ST_RUN;
               bcnt_d  = k + AW'(1);
            end
         end
      end

      fc_d = fc_q;
      if (sb_out.vld && sb_out.eof && bus.out_ready && fc_q != 16'hFFFF) begin
         fc_d = fc_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         bcnt_q  <= '0;
         err_q   <= 1'b0;
         fc_q    <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         err_q   <= err_d;
         fc_q    <= fc_d;
      end
   end

   sideband_pipe #(.LAT(LAT)) u_sb (
      .clk    (clk),
      .rst    (rst),
      .en     (pipe_en),
      .sb_in  (sb_in),
      .sb_out (sb_out)
   );

   // Frame quarter selects the twiddle class; tiny frames have only x1.
   if (AW >= 2) begin : g_quarter
      assign bus.num_ciclo = k[AW-1:AW-2];
   end else begin : g_no_quarter
      assign bus.num_ciclo = TW_ONE;
   end

   assign bus.tw_addr   = k;
   assign bus.pipe_en   = pipe_en;
   assign bus.in_ready  = pipe_en;
   assign bus.out_valid = sb_out.vld;
   assign bus.out_sof   = sb_out.sof;
   assign bus.out_eof   = sb_out.eof;
   assign bus.err_sof   = err_q;
   assign bus.frame_cnt = fc_q;

endmodule

// File: tb/tb_twiddle_stage_ctrl.sv
// Directed bench for twiddle_stage_ctrl with N=128, P=4, LAT=2 (32 beats/frame).
// A negedge monitor tracks delivered beats; all checks go through chk().
module tb_twiddle_stage_ctrl;
   import twiddle_stage_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   twiddle_stage_ctrl_if #(.AW(TW_AW)) bus ();

   twiddle_stage_ctrl #(.N(128), .P(4), .LAT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   int out_cnt = 0, eof_cnt = 0, err_cnt = 0, seq_bad = 0, out_idx = 0;
   int first_out_cyc = 0, last_out_cyc = 0, sof_out_cyc = 0, eof_out_cyc = 0;

   always @(negedge clk) begin
      if (bus.err_sof) err_cnt++;
      if (bus.out_valid && bus.out_ready) begin
         if (out_cnt == 0) first_out_cyc = cyc;
         last_out_cyc = cyc;
         out_cnt++;
         if (bus.out_sof) begin
            out_idx = 0;
            sof_out_cyc = cyc;
         end else begin
            out_idx++;
         end
         if (bus.out_eof !== (out_idx == 31)) seq_bad++;
         if (bus.out_eof) begin
            eof_cnt++;
            eof_out_cyc = cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      out_cnt = 0;
      eof_cnt = 0;
      err_cnt = 0;
   endtask

   // Present one beat and wait (bounded) until it is accepted.
   task automatic drive_beat(input logic sof, input int k);
      int   w = 0;
      logic rdy;
      bus.in_valid = 1'b1;
      bus.in_sof   = sof;
      #1;
      chk("tw_addr", 32'(bus.tw_addr), k);
      chk("num_ciclo", 32'(bus.num_ciclo), k / 8);
      do begin
         @(negedge clk);
         rdy = bus.in_ready;
         if (rdy) acc_cyc = cyc;
         @(posedge clk);
         #1;
         w++;
      end while (!rdy && w < 50);
      if (!rdy) chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic drain();
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic clean_frame(input int fc_exp);
      int sof_acc;
      clear_mon();
      drive_beat(1'b1, 0);
      sof_acc = acc_cyc;
      for (int k = 1; k < 32; k++) drive_beat(1'b0, k);
      drain();
      chk("clean_out_count", out_cnt, 32);
      chk("clean_sof_lat", sof_out_cyc - sof_acc, 2);
      chk("clean_eof_lat", eof_out_cyc - sof_acc, 33);
      chk("clean_eof_count", eof_cnt, 1);
      chk("clean_frame_cnt", 32'(bus.frame_cnt), fc_exp);
      chk("clean_no_err", err_cnt, 0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_sof", 32'(bus.out_sof), 0);
      chk("rst_out_eof", 32'(bus.out_eof), 0);
      chk("rst_err_sof", 32'(bus.err_sof), 0);
      chk("rst_frame_cnt", 32'(bus.frame_cnt), 0);
      chk("rst_tw_addr", 32'(bus.tw_addr), 0);
      chk("rst_num_ciclo", 32'(bus.num_ciclo), 0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      // Single clean frame
      clean_frame(1);

      // Two frames back-to-back
      clear_mon();
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < 32; k++) drive_beat(k == 0, k);
      drain();
      chk("b2b_out_count", out_cnt, 64);
      chk("b2b_no_gap", last_out_cyc - first_out_cyc, 63);
      chk("b2b_eof_count", eof_cnt, 2);
      chk("b2b_frame_cnt", 32'(bus.frame_cnt), 3);

      // out_ready low for 5 cycles mid-frame
      clear_mon();
      for (int k = 0; k < 12; k++) drive_beat(k == 0, k);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_sof    = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(bus.in_ready), 0);
         chk("stall_pipe_en", 32'(bus.pipe_en), 0);
         chk("stall_out_valid", 32'(bus.out_valid), 1);
         chk("stall_tw_addr", 32'(bus.tw_addr), 12);
         @(posedge clk);
         #1;
      end
      chk("stall_out_count", out_cnt, 10);
      bus.out_ready = 1'b1;
      for (int k = 12; k < 32; k++) drive_beat(1'b0, k);
      drain();
      chk("stall_total", out_cnt, 32);
      chk("stall_eof_count", eof_cnt, 1);
      chk("stall_frame_cnt", 32'(bus.frame_cnt), 4);

      // Premature sof at beat 10
      clear_mon();
      for (int k = 0; k < 10; k++) drive_beat(k == 0, k);
      drive_beat(1'b1, 0);
      for (int k = 1; k < 31; k++) drive_beat(1'b0, k);
      chk("presof_cnt_held", 32'(bus.frame_cnt), 4);
      drive_beat(1'b0, 31);
      drain();
      chk("presof_err_once", err_cnt, 1);
      chk("presof_eof_count", eof_cnt, 1);
      chk("presof_out_count", out_cnt, 42);
      chk("presof_frame_cnt", 32'(bus.frame_cnt), 5);

      // Beat without sof while idle
      clear_mon();
      bus.in_valid = 1'b1;
      bus.in_sof   = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("orphan_err_sof", 32'(bus.err_sof), 1);
      chk("orphan_out_valid", 32'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("orphan_err_pulse", 32'(bus.err_sof), 0);
      drain();
      chk("orphan_out_count", out_cnt, 0);
      chk("orphan_err_count", err_cnt, 1);
      chk("orphan_frame_cnt", 32'(bus.frame_cnt), 5);

      // Reset asserted at beat 20
      clear_mon();
      for (int k = 0; k < 20; k++) drive_beat(k == 0, k);
      bus.in_valid = 1'b1;
      rst = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 0);
      chk("arst_out_sof", 32'(bus.out_sof), 0);
      chk("arst_out_eof", 32'(bus.out_eof), 0);
      chk("arst_err_sof", 32'(bus.err_sof), 0);
      chk("arst_frame_cnt", 32'(bus.frame_cnt), 0);
      chk("arst_tw_addr", 32'(bus.tw_addr), 0);
      chk("arst_num_ciclo", 32'(bus.num_ciclo), 0);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_delivered", out_cnt, 18);
      chk("arst_no_eof", eof_cnt, 0);
      clean_frame(1);

      chk("sequence_ok", seq_bad, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/twiddle_stage_ctrl.md
TWIDDLE_STAGE_CTRL -- requirements
Module: twiddle_stage_ctrl

Interface
REQ-001 Parameter N, default 128, is the FFT length in points.
REQ-002 Parameter P, default 4, is the number of parallel lanes; beats per frame are B=N/P (default 32).
REQ-003 Parameter LAT, default 2, is the multiplier pipeline depth in beats that the sideband shall match; legal values are 1..4.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  an upstream beat (P complex samples) is presented.
REQ-007 in_sof  input  1  qualifies in_valid; marks beat 0 of a frame.
REQ-008 in_ready  output  1  the controller accepts the beat this cycle.
REQ-009 out_ready  input  1  downstream can take a beat.
REQ-010 num_ciclo  output  2  twiddle class select to the multipliers: 00/10 = x1, 01 = x(-j), 11 = CSD coefficient.
REQ-011 tw_addr  output  log2(B)  coefficient ROM address for the accepted beat.
REQ-012 pipe_en  output  1  clock enable for the multiplier pipeline registers.
REQ-013 out_valid, out_sof, out_eof  output  1 each  sideband aligned with the multiplier output.
REQ-014 err_sof  output  1  one-cycle pulse on a protocol error.
REQ-015 frame_cnt  output  16  count of completed frames, saturating at 16'hFFFF.

Function
REQ-016 Accept = in_valid && in_ready; pipe_en = !out_valid || out_ready; in_ready = pipe_en.
REQ-017 The FSM shall have two states: IDLE (no frame open) and RUN (beat counter bcnt in 1..B-1 expected next).
REQ-018 In IDLE, an accept with in_sof shall take beat 0, set bcnt=1, and go to RUN; when B==1 it shall instead stay in IDLE and emit eof.
REQ-019 In IDLE, an accept without in_sof shall be consumed and discarded (no out_valid), with err_sof pulsed the following cycle.
REQ-020 In RUN, an accept without in_sof shall use beat index bcnt and increment it; on bcnt==B-1 it shall return to IDLE and tag the beat eof.
REQ-021 In RUN, an accept with in_sof (premature sof) shall pulse err_sof, abandon the open frame without eof, treat the beat as beat 0, and set bcnt=1.
REQ-022 For the accepted beat index k, the controller shall drive tw_addr=k and num_ciclo=k[log2(B)-1:log2(B)-2] (the frame quarter), combinationally in the accept cycle.
REQ-023 The sideband {valid,sof,eof} shall traverse a LAT-stage shift register advanced only when pipe_en=1, so out_* appears exactly LAT enabled cycles after the accept.
REQ-024 When pipe_en=0, all pipeline stages, bcnt, and the state shall hold; no beat shall be lost or duplicated.
REQ-025 frame_cnt shall increment when a beat with eof leaves the pipeline (out_valid && out_eof && out_ready).
REQ-026 Back-to-back frames shall be accepted at one beat per cycle with no bubble: an sof beat in the cycle after eof is legal.

Reset
REQ-027 On assertion of rst (low), the block shall asynchronously enter IDLE with bcnt=0 and all pipeline valids cleared.
REQ-028 During reset, out_valid, out_sof, out_eof, err_sof=0, frame_cnt=0, num_ciclo=00, and tw_addr=0.
REQ-029 Deassertion shall be synchronous to clk; a frame in flight when reset asserts shall be dropped entirely.

Structure
REQ-030 A shared fft_pkg shall hold N, P, B, the log2(B) width, and the num_ciclo encodings (TW_ONE, TW_NEGJ, TW_CSD).
REQ-031 One sub-module, sideband_pipe (a LAT-deep enabled shift register of {valid,sof,eof}), shall be instantiated; the FSM and counters shall live in twiddle_stage_ctrl.

Verification
REQ-032 Single frame, out_ready=1: sof+32 beats give tw_addr 0..31; num_ciclo is 00 for beats 0-7, 01 for 8-15, 10 for 16-23, and 11 for 24-31; out_sof appears at cycle 2 and out_eof at cycle 33; frame_cnt=1.
REQ-033 Two frames back-to-back: exactly 64 out_valid with no gaps, and frame_cnt=2.
REQ-034 out_ready low for 5 cycles mid-frame: in_ready and pipe_en low, outputs frozen, and the beat sequence intact afterwards.
REQ-035 Premature sof at beat 10: err_sof pulses once, tw_addr restarts at 0, no out_eof for the aborted frame, and frame_cnt increments only after the new frame completes.
REQ-036 Beat without sof in IDLE: err_sof=1 next cycle and out_valid remains 0.
REQ-037 Reset asserted at beat 20: all outputs are 0 immediately, and a subsequent clean frame behaves as in REQ-032.
